cpu_stream_collector: RTL and testbench

- Synthesizable, parametrised collector for CPU_NB CPU data streams, each a 64-bit-class valid/ready channel.
- Buffers each channel in its own FIFO and merges them round-robin into one tagged output stream.
- Generates ready backpressure from a selectable mode, counts delivered transactions per CPU, and raises a completion flag once every CPU is done and all data has drained.
- Sits between the CPU instances and the consumer/scoreboard in the multiple-CPU testbench.

---
 rtl/cpu_stream_collector.sv | 192 +++++++++++++++++++
 tb/tb_cpu_stream_collector.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_stream_collector.sv
`timescale 1ns/1ps
// cpu_stream_collector
// Buffers CPU_NB valid/ready data channels in per-channel FIFOs and merges
// them round-robin into one registered, source-tagged output stream.
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   rdy_mode               input backpressure: 0/3 always, 1 LFSR, 2 never
//   in_vld/in_rdy/in_data  per-CPU input channels (channel i at [i*DATA_W +: DATA_W])
//   in_done                per-CPU done, latched sticky
//   out_vld/out_rdy/out_data/out_cpu_idx  merged output stream
//   cnt_sel/cnt_value      combinational read of a per-CPU delivered count
//   all_done               sticky completion flag
//   proto_err              sticky: write seen on an already-done channel
module cpu_stream_collector #(
  parameter int unsigned CPU_NB       = 4,
  parameter int unsigned DATA_W       = 64,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned DRAIN_CYCLES = 2,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1,
  localparam int unsigned IDX_W       = (CPU_NB > 1) ? $clog2(CPU_NB) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [1:0]               rdy_mode,
  input  logic [CPU_NB-1:0]        in_vld,
  output logic [CPU_NB-1:0]        in_rdy,
  input  logic [CPU_NB*DATA_W-1:0] in_data,
  input  logic [CPU_NB-1:0]        in_done,
  output logic                     out_vld,
  input  logic                     out_rdy,
  output logic [DATA_W-1:0]        out_data,
  output logic [IDX_W-1:0]         out_cpu_idx,
  input  logic [IDX_W-1:0]         cnt_sel,
  output logic [31:0]              cnt_value,
  output logic                     all_done,
  output logic                     proto_err
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = AW + 1;

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [15:0]       lfsr_q;
  logic [15:0]       lfsr_d;
  logic [PW-1:0]     wr_ptr_q [CPU_NB];
  logic [PW-1:0]     rd_ptr_q [CPU_NB];
  logic [DATA_W-1:0] mem_q    [CPU_NB][FIFO_DEPTH];
  logic [31:0]       cnt_q    [CPU_NB];
  logic [CPU_NB-1:0] done_q;
  logic              err_q;
  logic              out_vld_q;
  logic [DATA_W-1:0] out_data_q;
  logic [IDX_W-1:0]  out_idx_q;
  logic [IDX_W-1:0]  arb_ptr_q;
  logic [1:0]        state_q;
  logic [1:0]        state_d;
  logic [31:0]       drain_q;
  logic [31:0]       drain_d;

  logic [CPU_NB-1:0] empty;
  logic [CPU_NB-1:0] full;
  logic [CPU_NB-1:0] gate;
  logic [CPU_NB-1:0] wr;
  logic              load;
  logic              grant_vld;
  logic [IDX_W-1:0]  grant_idx;
  logic [IDX_W-1:0]  cand;

  // Galois LFSR, taps for x^16+x^14+x^13+x^11+1
  assign lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);

  // FIFO status from pointers carrying one extra wrap bit
  always_comb begin
    for (int i = 0; i < CPU_NB; i++) begin
      empty[i] = (wr_ptr_q[i] == rd_ptr_q[i]);
      full[i]  = (wr_ptr_q[i][AW] != rd_ptr_q[i][AW]) &&
                 (wr_ptr_q[i][AW-1:0] == rd_ptr_q[i][AW-1:0]);
    end
  end

  // Ready gating per mode; held low while reset is asserted
  always_comb begin
    for (int i = 0; i < CPU_NB; i++) begin
      case (rdy_mode)
        2'd1:    gate[i] = lfsr_q[i];
        2'd2:    gate[i] = 1'b0;
        default: gate[i] = 1'b1;
      endcase
    end
  end

  assign in_rdy = ~full & gate & {CPU_NB{rst_n}};
  assign wr     = in_vld & in_rdy;
  assign load   = !out_vld_q || out_rdy;

  // Round-robin search over non-empty FIFOs starting at arb_ptr_q
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = 0; k < CPU_NB; k++) begin
      cand = IDX_W'((32'(arb_ptr_q) + 32'(k)) % CPU_NB);
      if (!grant_vld && !empty[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  // Completion FSM next state
  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    case (state_q)
      ST_RUN: begin
        if ((&done_q) && (&empty) && !out_vld_q && !(|wr)) begin
          state_d = ST_DRAIN;
          drain_d = '0;
        end
      end
      ST_DRAIN: begin
        if ((|wr) || !(&empty)) begin
          state_d = ST_RUN;
        end else begin
          drain_d = drain_q + 32'd1;
          if (drain_d >= DRAIN_CYCLES) state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_DONE;
      default: state_d = ST_RUN;
    endcase
  end

  // FIFO storage; contents are don't-care until the pointers say otherwise
  always_ff @(posedge clk) begin
    for (int i = 0; i < CPU_NB; i++) begin
      if (wr[i]) mem_q[i][wr_ptr_q[i][AW-1:0]] <= in_data[i*DATA_W +: DATA_W];
    end
  end

  // Control, output register, counters and sticky flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q     <= LFSR_SEED;
      for (int i = 0; i < CPU_NB; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
      done_q     <= '0;
      err_q      <= 1'b0;
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
      out_idx_q  <= '0;
      arb_ptr_q  <= '0;
      state_q    <= ST_RUN;
      drain_q    <= '0;
    end else begin
      lfsr_q  <= lfsr_d;
      state_q <= state_d;
      drain_q <= drain_d;
      done_q  <= done_q | in_done;
      if (|(wr & done_q)) err_q <= 1'b1;
      for (int i = 0; i < CPU_NB; i++) begin
        if (wr[i]) wr_ptr_q[i] <= wr_ptr_q[i] + 1'b1;
      end
      if (out_vld_q && out_rdy && (cnt_q[out_idx_q] != 32'hFFFF_FFFF)) begin
        cnt_q[out_idx_q] <= cnt_q[out_idx_q] + 32'd1;
      end
      if (load) begin
        out_vld_q <= grant_vld;
        if (grant_vld) begin
          out_data_q          <= mem_q[grant_idx][rd_ptr_q[grant_idx][AW-1:0]];
          out_idx_q           <= grant_idx;
          rd_ptr_q[grant_idx] <= rd_ptr_q[grant_idx] + 1'b1;
          arb_ptr_q <= (32'(grant_idx) == CPU_NB - 1) ? '0 : grant_idx + 1'b1;
        end
      end
    end
  end

  assign out_vld     = out_vld_q;
  assign out_data    = out_data_q;
  assign out_cpu_idx = out_idx_q;
  assign all_done    = (state_q == ST_DONE);
  assign proto_err   = err_q;
  assign cnt_value   = (32'(cnt_sel) < CPU_NB) ? cnt_q[cnt_sel] : 32'd0;

endmodule

// File: tb/tb_cpu_stream_collector.sv
`timescale 1ns/1ps
// Randomised and directed bench for cpu_stream_collector against a queue-based model.
module tb_cpu_stream_collector;

  localparam int N     = 4;
  localparam int W     = 64;
  localparam int DEPTH = 4;
  localparam int DRAIN = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [1:0]     rdy_mode;
  logic [N-1:0]   in_vld;
  logic [N-1:0]   in_rdy;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_done;
  logic           out_vld;
  logic           out_rdy;
  logic [W-1:0]   out_data;
  logic [1:0]     out_cpu_idx;
  logic [1:0]     cnt_sel;
  logic [31:0]    cnt_value;
  logic           all_done;
  logic           proto_err;

  cpu_stream_collector #(
    .CPU_NB(N), .DATA_W(W), .FIFO_DEPTH(DEPTH), .DRAIN_CYCLES(DRAIN), .LFSR_SEED(16'hACE1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rdy_mode(rdy_mode),
    .in_vld(in_vld), .in_rdy(in_rdy), .in_data(in_data), .in_done(in_done),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_data(out_data), .out_cpu_idx(out_cpu_idx),
    .cnt_sel(cnt_sel), .cnt_value(cnt_value), .all_done(all_done), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Model state: FIFO contents as queues, output register, pointer, counters, flags
  logic [W-1:0] mq [N][$];
  bit           m_vld;
  logic [W-1:0] m_data;
  int           m_idx;
  int           m_ptr;
  logic [31:0]  m_cnt [N];
  logic [N-1:0] m_done;
  bit           m_err;
  logic [15:0]  m_lfsr;
  int           m_quiet;
  bit           m_all;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      mq[i].delete();
      m_cnt[i] = '0;
    end
    m_vld = 0; m_data = '0; m_idx = 0; m_ptr = 0;
    m_done = '0; m_err = 0; m_lfsr = 16'hACE1; m_quiet = 0; m_all = 0;
  endfunction

  function automatic bit m_rdy(int i);
    bit g;
    case (rdy_mode)
      2'd1:    g = m_lfsr[i];
      2'd2:    g = 1'b0;
      default: g = 1'b1;
    endcase
    return (mq[i].size() < DEPTH) && g && rst_n;
  endfunction

  // Model of one clock edge, from pre-edge state and current inputs
  function automatic void model_step(logic [N-1:0] wr);
    bit quiet;
    bit found;
    int c;
    quiet = (&m_done) && !m_vld && (wr == '0);
    for (int i = 0; i < N; i++) begin
      if (mq[i].size() != 0) quiet = 0;
      if (wr[i] && m_done[i]) m_err = 1;
    end
    if (m_vld && out_rdy && m_cnt[m_idx] != 32'hFFFF_FFFF) m_cnt[m_idx] = m_cnt[m_idx] + 1;
    if (!m_vld || out_rdy) begin
      found = 0;
      for (int k = 0; k < N; k++) begin
        c = (m_ptr + k) % N;
        if (!found && mq[c].size() != 0) begin
          found = 1;
          m_data = mq[c].pop_front();
          m_idx = c;
          m_ptr = (c + 1) % N;
        end
      end
      m_vld = found;
    end
    for (int i = 0; i < N; i++) if (wr[i]) mq[i].push_back(in_data[i*W +: W]);
    m_done = m_done | in_done;
    if (!m_all) begin
      m_quiet = quiet ? m_quiet + 1 : 0;
      if (m_quiet == DRAIN + 1) m_all = 1;
    end
    m_lfsr = {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
  endfunction

  // One cycle: check combinational outputs, step model at the edge, check registers at negedge
  task automatic cycle();
    logic [N-1:0] exp_rdy;
    #1;
    for (int i = 0; i < N; i++) exp_rdy[i] = m_rdy(i);
    chk("in_rdy", in_rdy, exp_rdy);
    chk("cnt_value", cnt_value, m_cnt[cnt_sel]);
    @(posedge clk);
    model_step(in_vld & exp_rdy);
    cyc++;
    @(negedge clk);
    chk("out_vld", out_vld, m_vld);
    chk("out_data", out_data, m_data);
    chk("out_cpu_idx", out_cpu_idx, 64'(m_idx));
    chk("all_done", all_done, m_all);
    chk("proto_err", proto_err, m_err);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0; in_vld = '0; in_done = '0; out_rdy = 0; in_data = '0; cnt_sel = '0;
    #1;
    chk("rst_in_rdy", in_rdy, 0);
    chk("rst_out_vld", out_vld, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_all_done", all_done, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    model_reset();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, guard, exp_idx, acc, got, last_hs, rise;
    bit started;
    rst_n = 0; rdy_mode = 0; in_vld = '0; in_data = '0; in_done = '0; out_rdy = 0; cnt_sel = '0;

    // Single channel latency and tagging
    do_reset();
    out_rdy = 1; in_vld = 4'b0010; in_data[1*W +: W] = 64'h1111_2222_3333_4444;
    cycle();
    chk("single_not_yet", out_vld, 0);
    in_vld = '0;
    cycle();
    chk("single_vld", out_vld, 1);
    chk("single_data", out_data, 64'h1111_2222_3333_4444);
    chk("single_idx", out_cpu_idx, 1);
    cycle();
    cnt_sel = 2'd1;
    #1 chk("single_cnt", cnt_value, 1);

    // Round-robin with all channels streaming
    do_reset();
    out_rdy = 1; in_vld = 4'hF;
    for (int i = 0; i < N; i++) in_data[i*W +: W] = 64'(i * 16);
    n = 0; guard = 0; exp_idx = 0; started = 0;
    while (n < 32 && guard < 200) begin
      if (started || out_vld) begin
        chk("rr_no_gap", out_vld, 1);
        started = 1;
      end
      if (out_vld) begin
        chk("rr_idx", out_cpu_idx, 64'(exp_idx));
        chk("rr_data", out_data, 64'(exp_idx * 16));
        exp_idx = (exp_idx + 1) % N;
        n++;
      end
      cycle();
      guard++;
    end
    chk("rr_transfers", 64'(n), 32);
    out_rdy = 0; in_vld = '0;
    for (int i = 0; i < N; i++) begin
      cnt_sel = 2'(i);
      #1 chk("rr_cnt", cnt_value, 8);
    end

    // Backpressure: FIFO plus output register hold five words
    do_reset();
    out_rdy = 0; acc = 0;
    for (int c = 0; c < 10; c++) begin
      in_vld = 4'b0001;
      in_data[0 +: W] = 64'hA0 + 64'(acc);
      if (m_rdy(0)) acc++;
      cycle();
    end
    chk("bp_accepted", 64'(acc), 5);
    chk("bp_held_data", out_data, 64'hA0);
    in_vld = '0;
    #1 chk("bp_in_rdy_low", in_rdy[0], 0);
    out_rdy = 1; got = 0; guard = 0;
    while (got < 5 && guard < 20) begin
      if (out_vld) begin
        chk("bp_word", out_data, 64'hA0 + 64'(got));
        got++;
      end
      cycle();
      guard++;
    end
    chk("bp_count", 64'(got), 5);
    chk("bp_no_dup", out_vld, 0);

    // Mode 2 never ready
    rdy_mode = 2'd2;
    do_reset();
    for (int c = 0; c < 100; c++) begin
      in_vld = 4'($urandom); out_rdy = 1'($urandom);
      cycle();
    end
    #1 chk("mode2_rdy", in_rdy, 0);

    // Mode 1 LFSR-gated ready from seed ACE1 -> E270 -> 7138
    rdy_mode = 2'd1;
    do_reset();
    #1 chk("lfsr_0", in_rdy, 4'b0001);
    cycle();
    #1 chk("lfsr_1", in_rdy, 4'b0000);
    cycle();
    #1 chk("lfsr_2", in_rdy, 4'b1000);

    // Completion latency after the last output handshake
    rdy_mode = 2'd0;
    do_reset();
    out_rdy = 1;
    for (int c = 0; c < 2; c++) begin
      in_vld = 4'hF;
      for (int i = 0; i < N; i++) in_data[i*W +: W] = {$urandom, $urandom};
      cycle();
    end
    in_vld = '0; in_done = 4'hF;
    last_hs = -100; rise = -1;
    for (int g = 0; g < 40; g++) begin
      if (out_vld) last_hs = cyc + 1;
      if (all_done && rise < 0) rise = cyc;
      cycle();
    end
    chk("done_latency", 64'(rise - last_hs), DRAIN + 1);

    // Write injected during DRAIN
    do_reset();
    out_rdy = 1; in_done = 4'hF;
    cycle();
    cycle();
    in_vld = 4'b0100; in_data[2*W +: W] = 64'h55;
    cycle();
    in_vld = '0;
    chk("drain_err", proto_err, 1);
    chk("drain_back_to_run", all_done, 0);
    for (int c = 0; c < 10; c++) cycle();
    chk("drain_eventually_done", all_done, 1);

    // Reset mid-operation with three words buffered
    do_reset();
    out_rdy = 1; in_done = 4'b1000;
    cycle();
    in_done = '0; in_vld = 4'b1000; in_data[3*W +: W] = 64'h33;
    cycle();
    in_vld = '0;
    cycle();
    cycle();
    out_rdy = 0;
    for (int c = 0; c < 3; c++) begin
      in_vld = 4'b0001; in_data[0 +: W] = 64'h100 + 64'(c);
      cycle();
    end
    in_vld = '0; cnt_sel = 2'd3;
    #1;
    chk("pre_rst_err", proto_err, 1);
    chk("pre_rst_cnt", cnt_value, 1);
    #1 rst_n = 0;
    #1;
    chk("mid_rst_vld", out_vld, 0);
    chk("mid_rst_err", proto_err, 0);
    chk("mid_rst_done", all_done, 0);
    chk("mid_rst_cnt", cnt_value, 0);
    @(negedge clk);
    rst_n = 1;
    model_reset();
    out_rdy = 1; in_vld = 4'b0010; in_data[1*W +: W] = 64'hBEEF;
    cycle();
    in_vld = '0;
    cycle();
    chk("post_rst_vld", out_vld, 1);
    chk("post_rst_data", out_data, 64'hBEEF);
    chk("post_rst_idx", out_cpu_idx, 1);

    // Randomised traffic across all modes
    do_reset();
    for (int c = 0; c < 800; c++) begin
      if (c % 25 == 0) rdy_mode = 2'($urandom);
      in_vld = 4'($urandom);
      for (int i = 0; i < N; i++) in_data[i*W +: W] = {$urandom, $urandom};
      out_rdy = ($urandom_range(0, 3) != 0);
      in_done = ($urandom_range(0, 80) == 0) ? 4'($urandom) : 4'b0000;
      cnt_sel = 2'($urandom);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
